// File: rtl/adder_disp_pkg.sv
// Shared types and constants for the adder / seven-segment display block.
// Holds the control FSM encoding and the active-low glyph table.
package adder_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    HEXLD = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; 10..15 use the A,b,C,d,E,F glyph shapes.
  function automatic logic [6:0] seg_lut(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle, WIDTH+1 steps after start.
// start is accepted only while idle; done flags the cycle whose closing edge makes the final step.
module bin_to_bcd_seq
  import adder_disp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH:0]        bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int N  = WIDTH + 1;
  localparam int BW = 4 * DIGITS;

  logic          busy_q, busy_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [N-1:0]  bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [BW-1:0] adj;
  logic          last;

  assign last = busy_q && (cnt_q == 4'(WIDTH));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    adj    = bcd_q;

    // Correct every digit that would overflow past 9 once doubled.
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end

    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = 4'd0;
        bin_d  = bin;
        bcd_d  = '0;
      end
    end else begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + 4'd1;
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      bin_q  <= '0;
      bcd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = last;
  assign bcd  = bcd_q;

endmodule

// File: rtl/adder_bcd_display.sv
// WIDTH-bit adder whose registered sum is shown on a 4-digit multiplexed active-low display.
// Result visible WIDTH+2 cycles after load (decimal) or 1 cycle (hex); load is dropped while busy.
module adder_bcd_display
  import adder_disp_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int REFRESH_BITS = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             load,
  input  logic             hex_mode,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp,
  output logic             co,
  output logic             busy,
  output logic             sum_valid
);

  localparam int SW = WIDTH + 1;
  localparam int BW = 4 * DIGITS;

  if (WIDTH < 1 || WIDTH > 12) begin : g_width_check
    $error("adder_bcd_display: WIDTH must be within 1..12");
  end

  if (REFRESH_BITS < 2) begin : g_refresh_check
    $error("adder_bcd_display: REFRESH_BITS must be at least 2");
  end

  state_e                  state_q, state_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic                    busy_q, busy_d;
  logic                    sum_valid_q, sum_valid_d;
  logic [BW-1:0]           digits_q, digits_d;
  logic                    disp_hex_q, disp_hex_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              an_q, an_d;
  logic                    dp_q, dp_d;

  logic [SW-1:0] sum_new;
  logic          eng_start;
  logic          eng_busy;
  logic          eng_done;
  logic [BW-1:0] eng_bcd;

  assign sum_new = {1'b0, a} + {1'b0, b} + SW'(ci);

  bin_to_bcd_seq #(
    .WIDTH (WIDTH)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (eng_start),
    .bin   (sum_new),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  // Control FSM: the display registers only change on the HEXLD/DONE update edge.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    busy_d      = busy_q;
    sum_valid_d = sum_valid_q;
    digits_d    = digits_q;
    disp_hex_d  = disp_hex_q;
    eng_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load && !eng_busy) begin
          sum_d       = sum_new;
          busy_d      = 1'b1;
          sum_valid_d = 1'b0;
          eng_start   = !hex_mode;
          state_d     = hex_mode ? HEXLD : CONV;
        end
      end
      CONV: begin
        if (eng_done) begin
          state_d = DONE;
        end
      end
      HEXLD: begin
        digits_d    = BW'(sum_q);
        disp_hex_d  = 1'b1;
        busy_d      = 1'b0;
        sum_valid_d = 1'b1;
        state_d     = IDLE;
      end
      DONE: begin
        digits_d    = eng_bcd;
        disp_hex_d  = 1'b0;
        busy_d      = 1'b0;
        sum_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [1:0] idx;
  logic [1:0] msd;
  logic [3:0] cur;
  logic       blank;

  // Scan mux: an and seg come from the same counter sample and are registered together.
  always_comb begin
    scan_d = scan_q + REFRESH_BITS'(1);
    idx    = scan_q[REFRESH_BITS-1 -: 2];
    cur    = digits_q[{idx, 2'b00} +: 4];

    msd = 2'd0;
    for (int i = 1; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] != 4'd0) begin
        msd = 2'(i);
      end
    end

    blank = !disp_hex_q && (idx > msd);
    seg_d = blank ? SEG_BLANK : seg_lut(cur);
    an_d  = ~(4'b0001 << idx);
    dp_d  = !(disp_hex_q && (idx == 2'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      digits_q    <= '0;
      disp_hex_q  <= 1'b0;
      scan_q      <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'b1111;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      busy_q      <= busy_d;
      sum_valid_q <= sum_valid_d;
      digits_q    <= digits_d;
      disp_hex_q  <= disp_hex_d;
      scan_q      <= scan_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign co        = sum_q[WIDTH];
  assign busy      = busy_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: doc/adder_bcd_display.md
Name: adder_bcd_display

Overview:
- Parametrised successor to the four-bit adder/display block. Adds two WIDTH-bit operands plus carry-in, registers the sum and carry-out, and converts the sum to BCD with a sequential shift-add-3 engine.
- Drives a 4-digit multiplexed active-low seven-segment display.
- Sits between the board switch/button inputs and the seven-segment pins, shown in either decimal or hex mode.

Parameters:
- WIDTH, 8, operand width; legal range 1..12, so the maximum sum fits 4 decimal digits.
- REFRESH_BITS, 17, width of the free-running scan counter; top 2 bits select the digit.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in
- load  input  1  capture strobe; sampled only while busy=0
- hex_mode  input  1  1 = hex display, 0 = decimal; captured with load
- seg  output  7  {g,f,e,d,c,b,a}, active low
- an  output  4  digit enables, active low one-hot; an[0] is the rightmost digit
- dp  output  1  decimal point, active low
- co  output  1  registered carry-out, sum[WIDTH]
- busy  output  1  conversion in progress
- sum_valid  output  1  displayed digits match the last accepted operands

Behaviour:
- Reset values (all outputs registered):
  - seg=7'b1111111, an=4'b1111, dp=1, co=0, busy=0, sum_valid=0.
  - Internal sum=0, digits=0, displayed mode=decimal, scan counter=0, state=IDLE.
- FSM states: IDLE, CONV, HEXLD, DONE.
- IDLE, load=1 at edge k:
  - Latch sum=a+b+ci (WIDTH+1 bits, no truncation) and co=sum[WIDTH].
  - Latch hex_mode; busy=1; sum_valid=0.
  - Go to CONV if decimal, HEXLD if hex.
- CONV: one shift-add-3 step per cycle, exactly WIDTH+1 steps (edges k+1..k+WIDTH+1), then DONE.
- HEXLD: at edge k+1, load digits from sum nibbles [3:0],[7:4],[11:8],[15:12] (zero-extended) and go to IDLE.
- DONE: at edge k+WIDTH+2, register the BCD digits to the display and return to IDLE.
- Completion:
  - Decimal: busy=0 and sum_valid=1 after edge k+WIDTH+2.
  - Hex: busy=0 and sum_valid=1 after edge k+1.
  - sum_valid stays high until the next accepted load.
- load while busy=1 is ignored: no queueing, no effect on the conversion in flight.
- The display keeps the previous digits until the update edge, so it never shows partial BCD.
- Scan:
  - Counter increments every cycle and wraps.
  - Digit index = counter[REFRESH_BITS-1:REFRESH_BITS-2]; index 0 drives an=4'b1110.
  - an and seg are registered together, so they never disagree.
- Decimal leading-zero blanking:
  - Any digit above the most-significant nonzero digit shows seg=7'b1111111 while its an is still asserted.
  - Digit 0 is never blanked.
- Hex mode: no blanking. Glyphs A,b,C,d,E,F.
- dp=0 only during the digit-0 slot when the displayed value is hex; dp=1 otherwise.
- After reset, before any load: decimal "0" on digit 0, other digits blank.
- Reset mid-conversion: aborts immediately to reset values; the next accepted load proceeds normally.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Error check: a synthesis-time error is raised for WIDTH outside 1..12.

Decomposition:
- Package adder_disp_pkg:
  - FSM state enum.
  - DIGITS=4.
  - SEG_BLANK.
  - 16-entry segment lookup function.
- Sub-module bin_to_bcd_seq: start/busy/done handshake, WIDTH+1-cycle shift-add-3, outputs 4 BCD digits.
- Scan mux, blanking and FSM stay in the top level.

Test Plan (WIDTH=8, REFRESH_BITS=4):
1. Reset held 3 cycles -> seg=1111111, an=1111, dp=1, co=0, busy=0, sum_valid=0. After release, digit-0 slot shows seg=1000000; other slots are blank.
2. Decimal: a=200, b=100, ci=1, load at edge k -> co=1 at k, busy through k+9, sum_valid=1 after k+10. Display shows "301":
   - an=0111 gives seg=1111111 (blank).
   - an=1011 gives 0110000 ("3").
   - an=1101 gives 1000000 ("0").
   - an=1110 gives 1111001 ("1").
   - dp=1 throughout.
3. Hex: a=8'hFF, b=8'h01, ci=0, hex_mode=1 -> co=1 and sum_valid=1 after k+1. Display shows "0100", dp=0 only in the an=1110 slot.
4. During case 2's conversion, pulse load with a=1, b=1 at k+3 -> ignored; the result is still 301 and sum_valid rises once, at k+10.
5. Decimal: a=0, b=0, ci=0 -> co=0; only digit 0 is lit (seg=1000000); an=0111/1011/1101 slots are blank.
6. rst asserted at k+4 of a decimal conversion -> next edge shows reset values. A new load of a=9, b=9, ci=0 then yields "18" and sum_valid=1 after WIDTH+2 edges.
